mem_lsu: RTL and testbench

//  - MEM stage load/store unit. Consumes exe_mem register outputs (mem_we/addr/data/op plus reg write-back triple).
//  - Runs req/gnt/rvalid transactions on the data bus: byte-lane steering for stores, extraction and sign/zero

---
 rtl/mem_lsu.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Runs one req/gnt/rvalid bus transaction per memory instruction. It steers store
// data onto byte lanes, and it extracts and sign/zero-extends load data. It holds
// stall_o high while an access is in flight. Non-memory instructions pass through
// combinationally.
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   reg_waddr_i/reg_we_i/reg_wdata_i    write-back triple from exe_mem
//   mem_we_i/mem_addr_i/mem_data_i/mem_op_i  memory request from exe_mem
//   reg_waddr_o/reg_we_o/reg_wdata_o    write-back triple to mem_wb/fw
//   stall_o, misalign_o, bus_err_o      hazard / status flags
//   dbus_*                              data bus master (req/gnt/rvalid)
module mem_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4:0]            reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [DATA_WIDTH-1:0] reg_wdata_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [3:0]            mem_op_i,
  output logic [4:0]            reg_waddr_o,
  output logic                  reg_we_o,
  output logic [DATA_WIDTH-1:0] reg_wdata_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [ADDR_WIDTH-1:0] dbus_addr_o,
  output logic [DATA_WIDTH-1:0] dbus_wdata_o,
  output logic [3:0]            dbus_be_o,
  input  logic                  dbus_gnt_i,
  input  logic                  dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dbus_rdata_i
);

  localparam logic [3:0] MEM_NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;
  localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [4:0]              rd_q, rd_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   ldata_q, ldata_d;

  logic                    access, misalign, is_load_q;
  logic [3:0]              be_c;
  logic [DATA_WIDTH-1:0]   wdata_c, ldata_fmt;
  logic [7:0]              lbyte;
  logic [15:0]             lhalf;

  assign access    = (mem_op_i != MEM_NOP);
  assign misalign  = ((mem_op_i == LH || mem_op_i == LHU || mem_op_i == SH) && mem_addr_i[0]) ||
                     ((mem_op_i == LW || mem_op_i == SW) && (mem_addr_i[1:0] != 2'b00));
  assign is_load_q = !we_q;

  // Lane steering; loads reuse the store byte-enable rules but send no data.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    case (mem_op_i)
      LB, LBU: be_c = 4'b0001 << mem_addr_i[1:0];
      LH, LHU: be_c = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      SB: begin
        be_c    = 4'b0001 << mem_addr_i[1:0];
        wdata_c = {4{mem_data_i[7:0]}};
      end
      SH: begin
        be_c    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_data_i[15:0]}};
      end
      SW: wdata_c = mem_data_i;
      default: be_c = 4'b1111;
    endcase
  end

  always_comb begin
    lbyte     = dbus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    lhalf     = dbus_rdata_i[{addr_q[1], 4'b0000} +: 16];
    ldata_fmt = dbus_rdata_i;
    case (op_q)
      LB:      ldata_fmt = {{24{lbyte[7]}}, lbyte};
      LBU:     ldata_fmt = {24'd0, lbyte};
      LH:      ldata_fmt = {{16{lhalf[15]}}, lhalf};
      LHU:     ldata_fmt = {16'd0, lhalf};
      default: ldata_fmt = dbus_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ldata_q <= ldata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ldata_d = ldata_q;
    case (state_q)
      S_IDLE: begin
        if (access && !misalign) begin
          op_d    = mem_op_i;
          addr_d  = mem_addr_i;
          rd_d    = reg_waddr_i;
          we_d    = mem_we_i;
          be_d    = be_c;
          wdata_d = wdata_c;
          cnt_d   = '0;
          err_d   = 1'b0;
          ldata_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Timeout wins over a same-cycle grant: no response could arrive in budget.
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TMO) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (dbus_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (dbus_rvalid_i) begin
          ldata_d = ldata_fmt;
          state_d = S_DONE;
        end else if (cnt_d == TMO) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so the bus sees the abort at once.
  always_comb begin
    reg_waddr_o  = '0;
    reg_we_o     = 1'b0;
    reg_wdata_o  = '0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_wdata_o = '0;
    dbus_be_o    = '0;
    if (!rst_i) begin
      case (state_q)
        S_IDLE: begin
          if (!access) begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
          end else if (misalign) begin
            misalign_o  = 1'b1;
            reg_waddr_o = reg_waddr_i;
            reg_wdata_o = reg_wdata_i;
          end else begin
            stall_o = 1'b1;
          end
        end
        S_REQ: begin
          stall_o      = 1'b1;
          dbus_req_o   = 1'b1;
          dbus_we_o    = we_q;
          dbus_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
          dbus_wdata_o = wdata_q;
          dbus_be_o    = be_q;
        end
        S_WAIT: stall_o = 1'b1;
        default: begin
          reg_waddr_o = rd_q;
          reg_we_o    = is_load_q && !err_q;
          reg_wdata_o = (is_load_q && !err_q) ? ldata_q : '0;
          bus_err_o   = err_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized aligned accesses,
// checked against an arithmetic reference model of lane steering and load format.
module tb_mem_lsu;
  localparam int T = 8;
  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk = 1'b0, rst;
  logic [4:0]  reg_waddr_i, reg_waddr_o;
  logic        reg_we_i, reg_we_o;
  logic [31:0] reg_wdata_i, reg_wdata_o;
  logic        mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [3:0]  mem_op_i;
  logic        stall_o, misalign_o, bus_err_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  int tests = 0, fails = 0;

  mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_op_i(mem_op_i),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic bit is_store(input logic [3:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int unsigned off = a % 4;
    if (op == LB || op == LBU || op == SB) return 4'(1 << off);
    if (op == LH || op == LHU || op == SH) return 4'(3 << off);
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == SB) return (d % 256) * 32'h0101_0101;
    if (op == SH) return (d % 65536) * 32'h0001_0001;
    if (op == SW) return d;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    int unsigned off = a % 4;
    logic [31:0] v;
    v = d;
    if (op == LB || op == LBU) begin
      v = (d >> (8 * off)) % 256;
      if (op == LB && v >= 128) v = v - 32'd256;
    end else if (op == LH || op == LHU) begin
      v = (d >> (8 * off)) % 65536;
      if (op == LH && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic set_nop();
    mem_op_i = NOP; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
  endtask

  // One aligned access. gd: REQ cycles before gnt; rvd: WAIT cycles before rvalid.
  task automatic run_access(input string nm, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata,
                            input logic [4:0] rd, input int gd, input int rvd);
    int exp_bus, reqs, waits;
    bit to, done;
    logic [31:0] exp_ld;
    exp_bus = gd + rvd + 2;
    to = exp_bus > T;
    if (to) exp_bus = T;
    exp_ld = (!is_store(op) && !to) ? m_load(op, addr, rdata) : 32'd0;
    @(posedge clk); #1;
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = is_store(op);
    reg_waddr_i = rd; reg_we_i = 1'b1; reg_wdata_i = $urandom;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    @(negedge clk);
    check({nm, " idle_stall"}, stall_o, 1);
    check({nm, " idle_noreq"}, dbus_req_o, 0);
    reqs = 0; waits = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(posedge clk); #1;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
      if (!stall_o) done = 1;
      else if (dbus_req_o) begin
        dbus_gnt_i = (reqs == gd);
        dbus_rvalid_i = 1'b1;          // stray response during REQ must be ignored
        dbus_rdata_i = ~rdata;
        reqs++;
        @(negedge clk);
        check({nm, " addr"}, dbus_addr_o, {addr[31:2], 2'b00});
        check({nm, " we"}, dbus_we_o, is_store(op));
        check({nm, " be"}, dbus_be_o, m_be(op, addr));
        check({nm, " wdata"}, dbus_wdata_o, m_wdata(op, data));
      end else begin
        dbus_rvalid_i = (waits == rvd);
        dbus_rdata_i = rdata;
        waits++;
      end
    end
    check({nm, " done_reached"}, done, 1);
    @(negedge clk);
    check({nm, " bus_cycles"}, reqs + waits, exp_bus);
    check({nm, " done_stall"}, stall_o, 0);
    check({nm, " done_rd"}, reg_waddr_o, rd);
    check({nm, " done_we"}, reg_we_o, !is_store(op) && !to);
    check({nm, " done_wdata"}, reg_wdata_o, exp_ld);
    check({nm, " done_err"}, bus_err_o, to);
    @(posedge clk); #1;
    set_nop();
    @(negedge clk);
    check({nm, " back_idle"}, {stall_o, dbus_req_o, bus_err_o}, 0);
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] a;
    int gd, rvd;
    set_nop();
    rst = 1'b1;
    reg_waddr_i = 5'd7; reg_we_i = 1'b1; reg_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("reset_outputs", {reg_waddr_o, reg_we_o, reg_wdata_o, stall_o, misalign_o, bus_err_o,
           dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU passthrough
    reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'h1234;
    #1;
    check("pass_rd", reg_waddr_o, 5);
    check("pass_we", reg_we_o, 1);
    check("pass_wdata", reg_wdata_o, 32'h1234);
    check("pass_stall_req", {stall_o, dbus_req_o}, 0);

    // Directed loads/stores
    run_access("lb", LB, 32'h103, 32'h0, 32'h80FF_0000, 5'd3, 0, 0);
    run_access("lbu", LBU, 32'h103, 32'h0, 32'h80FF_0000, 5'd4, 0, 0);
    run_access("sh", SH, 32'h202, 32'hABCD_1234, 32'h0, 5'd6, 0, 0);
    run_access("gnt_dly", LW, 32'h40, 32'h0, 32'h1357_9BDF, 5'd8, 4, 0);
    run_access("timeout", LW, 32'h80, 32'h0, 32'h0, 5'd9, 0, 100);
    run_access("tmo_req", SW, 32'h84, 32'h5555_AAAA, 32'h0, 5'd10, 20, 0);

    // Misaligned accesses: flagged, no bus activity
    @(posedge clk); #1;
    mem_op_i = LW; mem_addr_i = 32'h101; reg_we_i = 1'b1; reg_waddr_i = 5'd2;
    #1;
    check("mis_lw_flag", misalign_o, 1);
    check("mis_lw_stall_req_we", {stall_o, dbus_req_o, reg_we_o}, 0);
    @(posedge clk); #1;
    check("mis_lw_noreq_next", {dbus_req_o, stall_o}, 0);
    mem_op_i = SH; mem_addr_i = 32'h203; mem_we_i = 1'b1;
    #1;
    check("mis_sh_flag", {misalign_o, dbus_req_o, stall_o}, 3'b100);
    mem_op_i = LBU; mem_addr_i = 32'h203; mem_we_i = 1'b0;
    #1;
    check("lbu_odd_not_mis", {misalign_o, stall_o}, 2'b01);
    set_nop();
    @(posedge clk); #1;
    set_nop();

    // Async reset while in WAIT
    @(posedge clk); #1;
    mem_op_i = LW; mem_addr_i = 32'h300; reg_waddr_i = 5'd11; reg_we_i = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b1;
    @(posedge clk); #1;
    dbus_gnt_i = 1'b0;
    check("rst_pre_wait", {stall_o, dbus_req_o}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {reg_waddr_o, reg_we_o, reg_wdata_o, stall_o, misalign_o, bus_err_o,
           dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o}, 0);
    set_nop();
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    dbus_rvalid_i = 1'b0;
    #1;
    check("rst_idle_after", {stall_o, dbus_req_o, reg_we_o}, 0);
    run_access("post_rst_lw", LW, 32'h304, 32'h0, 32'hCAFE_F00D, 5'd12, 1, 1);

    // Randomized aligned accesses
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom;
      if (op == LW || op == SW) a[1:0] = 2'b00;
      else if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
      gd = $urandom_range(0, 3);
      rvd = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
      run_access("rand", op, a, $urandom, $urandom, 5'($urandom_range(1, 31)), gd, rvd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
